// File: rtl/apb_spi_pkg.sv
// Shared register map, bit positions and FSM encoding for the APB SPI front end.
package apb_spi_pkg;

   // Word-aligned register offsets
   localparam logic [3:0] CTRL_A   = 4'h0;
   localparam logic [3:0] STATUS_A = 4'h4;
   localparam logic [3:0] TXDATA_A = 4'h8;
   localparam logic [3:0] RXDATA_A = 4'hC;

   // CTRL bit positions
   localparam int CTRL_EN   = 0;
   localparam int CTRL_MSB  = 1;
   localparam int CTRL_RXIE = 2;

   // STATUS bit positions
   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_EMPTY = 2;
   localparam int ST_RX_FULL  = 3;
   localparam int ST_BUSY     = 4;
   localparam int ST_OVF      = 5;

   typedef enum logic {IDLE, ACTIVE} state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with resettable storage and occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only possible when the head leaves the same cycle
   assign do_push = push & (~full | pop);
   assign do_pop  = pop & ~empty;

   // Storage, pointers and count
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/apb_spi_ctrl.sv
// APB register front end feeding TX/RX FIFOs around a CPOL=1/CPHA=1 SPI byte engine.
module apb_spi_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [3:0]  paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr,
   output logic [7:0]  byte_2_send,
   input  logic [7:0]  byte_received,
   input  logic        end_trans,
   output logic        ena_spi,
   output logic        msb_lsb,
   output logic        irq
);
   import apb_spi_pkg::*;

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          wr;
   logic          rd;
   logic [3:0]    addr;
   logic          en_q;
   logic          msb_q;
   logic          rxie_q;
   logic          ovf_q;
   logic          ctrl_we;
   logic          ovf_clr;
   logic          ovf_set;
   logic          st_wr_bad;
   logic          busy;
   state_t        state_q;
   state_t        state_d;

   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic [CW-1:0] tx_count;
   logic [CW-1:0] tx_left;
   logic [7:0]    tx_head;
   logic          rx_push, rx_pop, rx_full, rx_empty;
   logic [CW-1:0] rx_count;
   logic [7:0]    rx_head;
   logic          unused;

   assign wr        = psel & penable & pwrite;
   assign rd        = psel & penable & ~pwrite;
   assign addr      = {paddr[3:2], 2'b00};
   assign st_wr_bad = |{pwdata[31:6], pwdata[4:0]};
   assign busy      = (state_q == ACTIVE);
   assign unused    = ^{paddr[1:0], rx_count};

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .arst  (arst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (pwdata[7:0]),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .arst  (arst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (byte_received),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // APB decode: read mux, write strobes and error response
   always_comb begin
      prdata  = '0;
      pslverr = 1'b0;
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      ctrl_we = 1'b0;
      ovf_clr = 1'b0;
      if (psel && !pwrite) begin
         case (addr)
            CTRL_A:   prdata = {29'b0, rxie_q, msb_q, en_q};
            STATUS_A: prdata = {26'b0, ovf_q, busy, rx_full, rx_empty, tx_full, tx_empty};
            RXDATA_A: prdata = rx_empty ? 32'b0 : {24'b0, rx_head};
            default:  prdata = '0;
         endcase
      end
      if (wr) begin
         case (addr)
            CTRL_A:   ctrl_we = 1'b1;
            STATUS_A: begin
               if (st_wr_bad) pslverr = 1'b1;
               else           ovf_clr = pwdata[ST_OVF];
            end
            TXDATA_A: begin
               if (tx_full) pslverr = 1'b1;
               else         tx_push = 1'b1;
            end
            default:  pslverr = 1'b1;
         endcase
      end
      if (rd && addr == RXDATA_A) begin
         if (rx_empty) pslverr = 1'b1;
         else          rx_pop  = 1'b1;
      end
   end

   // TX occupancy once this cycle's engine pop and APB push have both landed
   assign tx_left = tx_count - CW'(1) + CW'(tx_push);

   // Control FSM: keeps the engine enabled while bytes remain and EN holds
   always_comb begin
      state_d = state_q;
      tx_pop  = 1'b0;
      rx_push = 1'b0;
      case (state_q)
         IDLE: begin
            if (en_q && !tx_empty) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (end_trans) begin
               tx_pop  = 1'b1;
               rx_push = 1'b1;
               if (tx_left == '0 || !en_q) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ovf_set = rx_push & rx_full & ~rx_pop;

   // FSM state register
   always_ff @(posedge clk or posedge arst) begin
      if (arst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // CTRL register; bit order is frozen while a burst is running
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         en_q   <= 1'b0;
         msb_q  <= 1'b1;
         rxie_q <= 1'b0;
      end else if (ctrl_we) begin
         en_q   <= pwdata[CTRL_EN];
         rxie_q <= pwdata[CTRL_RXIE];
         if (!busy) msb_q <= pwdata[CTRL_MSB];
      end
   end

   // Sticky RX overflow flag; a new overflow beats a same-cycle clear
   always_ff @(posedge clk or posedge arst) begin
      if (arst)         ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
   end

   assign ena_spi     = busy;
   assign msb_lsb     = msb_q;
   assign byte_2_send = tx_head;
   assign pready      = 1'b1;
   assign irq         = (rxie_q & ~rx_empty) | ovf_q;

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Scoreboard bench for apb_spi_ctrl with a behavioural SPI engine (MISO looped to MOSI).
module tb_apb_spi_ctrl;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] data;
      logic        err;
      bit          rd;
   } exp_t;

   logic        clk = 1'b0;
   logic        arst;
   logic        psel, penable, pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;
   logic [7:0]  byte_2_send;
   logic [7:0]  byte_received;
   logic        end_trans;
   logic        ena_spi, msb_lsb, irq;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   bit          m_en, m_msb, m_rxie, m_ovf, m_active;
   logic [7:0]  tx_q[$];
   logic [7:0]  rx_q[$];
   exp_t        exp_q[$];

   // Engine model state
   int          eng_cnt;
   int          eng_len;
   logic [7:0]  eng_byte;

   apb_spi_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .arst          (arst),
      .psel          (psel),
      .penable       (penable),
      .pwrite        (pwrite),
      .paddr         (paddr),
      .pwdata        (pwdata),
      .prdata        (prdata),
      .pready        (pready),
      .pslverr       (pslverr),
      .byte_2_send   (byte_2_send),
      .byte_received (byte_received),
      .end_trans     (end_trans),
      .ena_spi       (ena_spi),
      .msb_lsb       (msb_lsb),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   // SPI engine: latch the byte, shift for a random length, pulse end_trans, short gap
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         eng_cnt       <= 0;
         eng_len       <= 4;
         eng_byte      <= 8'h00;
         end_trans     <= 1'b0;
         byte_received <= 8'h00;
      end else begin
         end_trans <= 1'b0;
         if (eng_cnt == 0) begin
            if (ena_spi) begin
               eng_byte <= byte_2_send;
               eng_len  <= $urandom_range(3, 8);
               eng_cnt  <= 1;
            end
         end else if (eng_cnt == eng_len) begin
            end_trans     <= 1'b1;
            byte_received <= eng_byte;
            eng_cnt       <= eng_cnt + 1;
         end else if (eng_cnt == eng_len + 2) begin
            eng_cnt <= 0;
         end else begin
            eng_cnt <= eng_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_en = 0; m_msb = 1; m_rxie = 0; m_ovf = 0; m_active = 0;
      tx_q.delete();
      rx_q.delete();
   endfunction

   // One clock of behaviour: APB side effects, engine byte completion, burst control
   function automatic void model_step();
      bit         acc, wr, rd, rx_pop, tx_push, et, ovf_set, act, en_old;
      int         pre_rx, pre_tx;
      logic [3:0] a;
      logic [7:0] b;
      acc     = psel && penable;
      wr      = acc && pwrite;
      rd      = acc && !pwrite;
      a       = paddr & 4'hC;
      et      = end_trans;
      pre_rx  = rx_q.size();
      pre_tx  = tx_q.size();
      act     = m_active;
      en_old  = m_en;
      ovf_set = 0;
      rx_pop  = rd && a == 4'hC && pre_rx > 0;
      tx_push = wr && a == 4'h8 && pre_tx < DEPTH;
      if (rx_pop) void'(rx_q.pop_front());
      if (act && et) begin
         b = tx_q.pop_front();
         if (pre_rx < DEPTH || rx_pop) rx_q.push_back(b);
         else ovf_set = 1;
      end
      if (tx_push) tx_q.push_back(pwdata[7:0]);
      if (wr && a == 4'h0) begin
         m_en   = pwdata[0];
         m_rxie = pwdata[2];
         if (!act) m_msb = pwdata[1];
      end
      if (wr && a == 4'h4 && (pwdata & ~32'h20) == 0 && pwdata[5]) m_ovf = 0;
      if (ovf_set) m_ovf = 1;
      if (!act) m_active = en_old && pre_tx > 0;
      else if (et && (tx_q.size() == 0 || !en_old)) m_active = 0;
   endfunction

   function automatic exp_t model_expect(input bit wr, input logic [3:0] a, input logic [31:0] d);
      exp_t e;
      e.data = '0;
      e.err  = 1'b0;
      e.rd   = !wr;
      case (a & 4'hC)
         4'h0: if (!wr) e.data = {29'b0, m_rxie, m_msb, m_en};
         4'h4: begin
            if (wr) e.err = (d & ~32'h20) != 0;
            else e.data = {26'b0, m_ovf, m_active, rx_q.size() == DEPTH, rx_q.size() == 0,
                           tx_q.size() == DEPTH, tx_q.size() == 0};
         end
         4'h8: if (wr) e.err = tx_q.size() == DEPTH;
         default: begin
            if (wr || rx_q.size() == 0) e.err = 1'b1;
            else e.data = {24'b0, rx_q[0]};
         end
      endcase
      return e;
   endfunction

   // Model follows the same clock and asynchronous reset as the design
   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge arst);
         if (arst) model_reset();
         else model_step();
      end
   end

   // Monitor: level outputs every cycle, scoreboard pop on each completed access
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!arst) begin
            chk("ena_spi", ena_spi, m_active);
            chk("irq", irq, (m_rxie && rx_q.size() > 0) || m_ovf);
            chk("msb_lsb", msb_lsb, m_msb);
            chk("pready", pready, 1);
            if (psel && penable) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL scoreboard: access completed with no expected entry at %0t", $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("pslverr", pslverr, e.err);
                  if (e.rd) chk("prdata", prdata, e.data);
               end
            end
         end
      end
   end

   // Starts and ends one clock after a rising edge
   task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] d);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = d;
      @(posedge clk); #1;
      penable = 1'b1;
      exp_q.push_back(model_expect(wr, a, d));
      @(posedge clk); #1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int i;
      for (i = 0; i < max; i++) begin
         if (!m_active && !(m_en && tx_q.size() > 0)) break;
         @(posedge clk); #1;
      end
      n_cmp++;
      if (i == max) begin
         n_fail++;
         $display("FAIL wait_idle: burst still running after %0d cycles", max);
      end
   endtask

   task automatic wait_end_trans(input int max);
      int i;
      for (i = 0; i < max; i++) begin
         @(posedge clk);
         if (end_trans) break;
      end
      #1;
      n_cmp++;
      if (i == max) begin
         n_fail++;
         $display("FAIL wait_end_trans: no end_trans within %0d cycles", max);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int          n, r;
      logic [31:0] d;
      psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      arst = 1'b1;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;

      // Reset state of all registers
      apb(0, 4'h0, 0);
      apb(0, 4'h4, 0);
      apb(0, 4'h8, 0);
      apb(0, 4'hC, 0);
      chk("byte_2_send_reset", byte_2_send, 0);

      // Three-byte burst with loopback, then drain RX past empty
      apb(1, 4'h0, 32'h3);
      apb(1, 4'h8, 32'hA5);
      apb(1, 4'h8, 32'h3C);
      apb(1, 4'h8, 32'hFF);
      wait_idle(400);
      repeat (4) apb(0, 4'hC, 0);

      // Fill TX with EN=0: fifth write is rejected, nothing moves
      apb(1, 4'h0, 32'h2);
      for (int i = 0; i < 5; i++) apb(1, 4'h8, $urandom_range(0, 255));
      apb(0, 4'h4, 0);
      repeat (10) @(posedge clk);
      #1;
      apb(1, 4'h0, 32'h3);
      wait_idle(400);
      repeat (5) apb(0, 4'hC, 0);

      // RX overflow with RXIE and LSB-first, then W1C of ovf
      apb(1, 4'h0, 32'h5);
      for (int i = 0; i < 5; i++) begin
         apb(1, 4'h8, $urandom_range(0, 255));
         wait_idle(200);
      end
      apb(0, 4'h4, 0);
      apb(1, 4'h4, 32'h21);
      apb(1, 4'h4, 32'h20);
      apb(0, 4'h4, 0);
      apb(1, 4'hC, 32'h0);
      repeat (5) apb(0, 4'hC, 0);

      // Clear EN during the second byte; the MSB change in that write must not stick
      apb(1, 4'h0, 32'h0);
      for (int i = 0; i < 4; i++) apb(1, 4'h8, $urandom_range(0, 255));
      apb(1, 4'h0, 32'h1);
      wait_end_trans(100);
      apb(1, 4'h0, 32'h2);
      wait_idle(200);
      apb(0, 4'h4, 0);
      repeat (3) apb(0, 4'hC, 0);
      apb(1, 4'h0, 32'h3);
      wait_idle(200);
      repeat (3) apb(0, 4'hC, 0);

      // Randomized mix of accesses against the model
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1: apb(1, 4'h0 | 4'($urandom_range(0, 3)),
                      {29'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 3) != 0)});
            2: begin
               d = ($urandom_range(0, 3) == 0) ? $urandom : 32'h20;
               apb(1, 4'h4, d);
            end
            3, 4, 5: apb(1, 4'h8 | 4'($urandom_range(0, 3)), $urandom);
            6, 7, 8: apb(0, 4'hC | 4'($urandom_range(0, 3)), 0);
            default: apb($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), 0);
         endcase
         n = $urandom_range(0, 3);
         if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
         end
      end
      apb(1, 4'h0, 32'h3);
      wait_idle(400);
      apb(0, 4'h4, 0);

      // Asynchronous reset in the middle of a byte
      apb(1, 4'h0, 32'h3);
      for (int i = 0; i < 3; i++) apb(1, 4'h8, $urandom_range(0, 255));
      repeat (6) @(posedge clk);
      #3 arst = 1'b1;
      #1 chk("ena_spi_async_reset", ena_spi, 0);
      @(posedge clk);
      #1 arst = 1'b0;
      chk("byte_2_send_after_reset", byte_2_send, 0);
      apb(0, 4'h4, 0);
      apb(0, 4'h0, 0);
      repeat (20) @(posedge clk);
      #1;
      apb(0, 4'h4, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_spi_ctrl.md
# apb_spi_ctrl

APB slave front end for the SPI byte engine (`spi_interface`, CPOL=1/CPHA=1). Software queues bytes into a TX FIFO and reads received bytes from an RX FIFO through four APB registers. The block drives the engine's `byte_2_send`, `ena_spi` and `msb_lsb` inputs, and consumes its `byte_received` and `end_trans` outputs, so that bursts run back-to-back under a single CS assertion.

## Interface
- FIFO_DEPTH, 4, entries per FIFO; must be a power of two and ≥2
- clk  in  1  system clock
- arst  in  1  asynchronous reset, active-high
- psel, penable, pwrite  in  1 each  APB control
- paddr  in  4  byte address; bits [1:0] are ignored
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  tied to 1 (zero wait states)
- pslverr  out  1  error response
- byte_2_send  out  8  TX FIFO head (show-ahead) to the engine
- byte_received  in  8  engine RX byte, valid while end_trans=1
- end_trans  in  1  one-cycle engine pulse marking the end of a byte
- ena_spi  out  1  engine enable (registered)
- msb_lsb  out  1  bit order (1 = MSB first)
- irq  out  1  level interrupt

## Operation
- Register map:
  - 0x0 CTRL (RW): bit0 EN, bit1 MSB (reset 1), bit2 RXIE. All other bits read 0.
  - 0x4 STATUS (RO except bit5): bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 busy, bit5 ovf (sticky; write 1 to clear).
  - 0x8 TXDATA (WO): a write pushes pwdata[7:0]. Reads return 0.
  - 0xC RXDATA (RO): a read pops the RX head and returns it in prdata[7:0].
- An APB access takes effect on the clk edge where psel & penable. Write accesses and read accesses are decoded separately.
- pslverr=1 (with no state change) in these cases:
  - TXDATA write while tx_full.
  - RXDATA read while rx_empty; prdata is 0.
  - Write to STATUS bits other than 5, or to RXDATA.
  - Any other access is OKAY.
- A CTRL.MSB write while busy is ignored; the bit holds its value. msb_lsb = CTRL.MSB.
- Control FSM:
  - IDLE: ena_spi=0. If EN & !tx_empty, go to ACTIVE.
  - ACTIVE: ena_spi=1. On each end_trans:
    - Push byte_received into the RX FIFO.
    - Pop the TX head.
    - If (TX count after the pop and any same-cycle push) == 0, or EN==0, go to IDLE.
- busy = (state == ACTIVE).
- Clearing EN mid-byte is graceful: the current byte completes, then the FSM stops at end_trans.
- RX push rules:
  - Accepted if !rx_full, or if an APB RXDATA pop occurs in the same cycle.
  - Otherwise the byte is dropped and ovf is set.
  - ovf set and W1C in the same cycle: set wins.
- TX push rules:
  - Accepted only if !tx_full before the cycle.
  - A simultaneous push and pop leaves the count unchanged.
- irq = (RXIE & !rx_empty) | ovf.
- FIFOs:
  - Pointers have $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Count has $clog2(FIFO_DEPTH)+1 bits.
  - full = (count == FIFO_DEPTH); empty = (count == 0).

## Timing
- Reset values:
  - ena_spi=0, pslverr=0, prdata=0, irq=0, msb_lsb=1.
  - byte_2_send=0 (the FIFO storage is reset).
  - FIFOs empty, CTRL=0x2, ovf=0, FSM in IDLE.
- arst mid-burst: ena_spi falls asynchronously, which aborts the engine (CS rises). Queued data is lost.
- ena_spi rises 1 cycle after the clock edge where EN & !tx_empty is first seen in IDLE.
- ena_spi falls on the cycle after the final end_trans. This is before the engine's WAIT_AFTER expires, so no extra byte is clocked.
- byte_2_send changes only on a TX pop, or on a push into an empty FIFO. It is therefore stable through the engine's LOAD_BYTE.
- prdata is combinational from paddr and the FIFO head during the access phase. The RX pop occurs at the end of the access.
- STATUS reflects the state registered at the start of the cycle.

## Structure
- Package apb_spi_pkg holds:
  - Register offsets (CTRL_A=0x0, STATUS_A=0x4, TXDATA_A=0x8, RXDATA_A=0xC).
  - CTRL and STATUS bit indices.
  - The FSM enum (IDLE, ACTIVE).
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Show-ahead read, push/pop/full/empty/count.
  - Instantiated twice (TX, RX).
- Top level: APB decode, CTRL/ovf registers, control FSM.

## Test plan
- Reset, then read all registers → CTRL=0x2, STATUS=0x5 (tx_empty, rx_empty). ena_spi=0, irq=0.
- Three-byte burst:
  - Set EN=1 and MSB=1, then write TXDATA 0xA5, 0x3C, 0xFF with the engine MISO loopback attached.
  - → ena_spi stays high for exactly 3 end_trans pulses, then drops.
  - → RXDATA reads return 0xA5, 0x3C, 0xFF, then the next read returns pslverr=1.
- Write 5 bytes with EN=0, FIFO_DEPTH=4 → the fifth write returns pslverr=1, STATUS.tx_full=1, no SPI activity.
- RX overflow:
  - Send 5 bytes without reading RX → ovf=1 and irq=1; RX holds bytes 1–4.
  - Write 0x20 to STATUS → ovf=0.
- Clear EN during the second of four queued bytes → exactly 2 end_trans occur, then ena_spi=0, tx count=2.
- Assert arst mid-byte → ena_spi=0 immediately; after release STATUS=0x5, CTRL=0x2.
